input_debouncer: RTL
====================

# input_debouncer

Input conditioning stage between the board pins and `top`. Synchronises the four slide switches and the north push-button to `CLK_50MHZ`, debounces each group with a reload counter, and produces stable levels plus single-cycle change/press/release strobes. `top` consumes `SW_STABLE` in place of raw `SW3..SW0` and `BTN_PRESS` in place of raw `BTN_NORTH`.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before accepting a new value (10 ms at 50 MHz); legal minimum 2.
- `CNT_W`, default 19: debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- `CLK_50MHZ`  in  1  sole clock; all state updates on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `SW3`, `SW2`, `SW1`, `SW0`  in  1 each  raw asynchronous switch pins.
- `BTN_NORTH`  in  1  raw asynchronous button pin, 1 = pressed.
- `SW_STABLE`  out  4  debounced `{SW3,SW2,SW1,SW0}`.
- `SW_CHANGED`  out  1  one-cycle strobe when `SW_STABLE` updates.
- `BTN_LEVEL`  out  1  debounced button level.
- `BTN_PRESS`  out  1  one-cycle strobe on `BTN_LEVEL` 0->1.
- `BTN_RELEASE`  out  1  one-cycle strobe on `BTN_LEVEL` 1->0.

## Operation
- Reset: all synchroniser flops, candidates, counters and outputs = 0. `SW_STABLE`=0000, `BTN_LEVEL`=0, all strobes 0.
- Synchroniser: two flops per input (`s1`, then `s2`). `s1` and `s2` reset to 0.
- Switch channel, 4-bit group. Registers `sw_cand`, `sw_cnt`.
  - `s2 != sw_cand`: `sw_cand <= s2`, `sw_cnt <= 0`.
  - `s2 == sw_cand != SW_STABLE`, with `sw_cnt == DEBOUNCE_CYCLES-1`: `SW_STABLE <= sw_cand`, `SW_CHANGED <= 1`, `sw_cnt <= 0`.
  - `s2 == sw_cand != SW_STABLE`, otherwise: `sw_cnt <= sw_cnt + 1`.
  - `s2 == sw_cand == SW_STABLE`: `sw_cnt <= 0`.
  - Any bit change restarts the whole group. Bounce back to the stable value yields no output change.
- Button channel: identical structure, 1 bit (`bt_cand`, `bt_cnt`).
  - On accept: `BTN_LEVEL <= bt_cand`.
  - `BTN_PRESS <= bt_cand`. `BTN_RELEASE <= ~bt_cand`.
- Strobes are registered. They default to 0 every cycle not accepting, so each is high for exactly one cycle.
- The switch and button channels are independent. Simultaneous accepts assert both strobes on the same edge.
- Counter never exceeds `DEBOUNCE_CYCLES-1`; no wrap.

## Timing
- Latency: a pin change held steady is first sampled at edge 1. The output register and strobe update at edge `DEBOUNCE_CYCLES+3`, breaking down as:
  - 2 edges synchroniser;
  - 1 edge candidate load;
  - `DEBOUNCE_CYCLES` counting edges.
- Pulses shorter than `DEBOUNCE_CYCLES+1` cycles at `s2` are rejected.
- Reset mid-count: on the edge `RESET` is sampled high, all state clears. Partial counts are discarded.
- After `RESET` falls, a pin held non-zero is accepted `DEBOUNCE_CYCLES+3` edges later. It produces `SW_CHANGED` or `BTN_PRESS` exactly as for a fresh change.
- While `RESET` is high, strobes stay 0 regardless of pins.
- Throughput: after an accept, the next accept requires at least `DEBOUNCE_CYCLES+1` further edges, because the candidate reload and count restart.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4, `CNT_W`=3. Latency is therefore 7 edges.
- Power-up: hold SW=0101 and `RESET`=1 for 3 edges, then drop `RESET`. Required: `SW_STABLE`=0000 until edge 7 after release, then 0101 with `SW_CHANGED` high for exactly 1 cycle.
- Button bounce: `BTN_NORTH` toggles 1,0,1,0,1 on consecutive edges, then holds 1. Required: `BTN_PRESS` exactly once, 7 edges after the final transition. `BTN_LEVEL`=1 thereafter, with no intermediate strobes.
- Switch glitch: `SW_STABLE`=0101. SW0 goes to 0 for 3 cycles, then returns to 1. Required: `SW_CHANGED` never asserts and `SW_STABLE` stays 0101.
- Release: with `BTN_LEVEL`=1, drop `BTN_NORTH` to 0 and hold. Required: at edge 7, `BTN_RELEASE`=1 for 1 cycle, `BTN_LEVEL`=0, `BTN_PRESS` stays 0.
- Reset mid-count: SW 0101->0100, then `RESET`=1 for one edge at edge 5. Required: outputs 0000 next edge. After release, `SW_STABLE`=0100 exactly 7 edges later, with one `SW_CHANGED`.
- Simultaneous: change SW to 1111 and `BTN_NORTH` to 1 on the same edge. Required: `SW_CHANGED` and `BTN_PRESS` both assert on the same edge, 7 edges later.

Source files
------------

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer
// Description : Board-pin conditioning for the four slide switches and the
//               north push-button. Each group is synchronised through two
//               flops and debounced with a reload counter. The block drives
//               stable levels and registered one-cycle change/press/release
//               strobes.
// Revision    : 1.0  initial release
// ============================================================================
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       CLK_50MHZ,
    input  logic       RESET,
    input  logic       SW3,
    input  logic       SW2,
    input  logic       SW1,
    input  logic       SW0,
    input  logic       BTN_NORTH,
    output logic [3:0] SW_STABLE,
    output logic       SW_CHANGED,
    output logic       BTN_LEVEL,
    output logic       BTN_PRESS,
    output logic       BTN_RELEASE
);

    // Final count value. The candidate is accepted on the edge where the
    // counter holds this value, so DEBOUNCE_CYCLES counting edges elapse.
    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [3:0]       w_sw_raw;

    // Synchroniser stages
    logic [3:0]       r_sw_s1;
    logic [3:0]       r_sw_s2;
    logic             r_bt_s1;
    logic             r_bt_s2;

    // Switch channel state
    logic [3:0]       r_sw_cand;
    logic [CNT_W-1:0] r_sw_cnt;
    logic [3:0]       r_sw_stable;
    logic             r_sw_changed;

    // Button channel state
    logic             r_bt_cand;
    logic [CNT_W-1:0] r_bt_cnt;
    logic             r_bt_level;
    logic             r_bt_press;
    logic             r_bt_release;

    // Channel decode
    logic             w_sw_new_cand;
    logic             w_sw_pending;
    logic             w_sw_accept;
    logic             w_bt_new_cand;
    logic             w_bt_pending;
    logic             w_bt_accept;

    assign w_sw_raw = {SW3, SW2, SW1, SW0};

    // Any difference between the synchronised pins and the candidate reloads
    // the whole group. A candidate that differs from the stable value
    // counts toward acceptance.
    assign w_sw_new_cand = (r_sw_s2 != r_sw_cand);
    assign w_sw_pending  = (r_sw_cand != r_sw_stable);
    assign w_sw_accept   = !w_sw_new_cand && w_sw_pending && (r_sw_cnt == c_cnt_max);

    assign w_bt_new_cand = (r_bt_s2 != r_bt_cand);
    assign w_bt_pending  = (r_bt_cand != r_bt_level);
    assign w_bt_accept   = !w_bt_new_cand && w_bt_pending && (r_bt_cnt == c_cnt_max);

    // Two-flop synchroniser on every raw pin
    always_ff @(posedge CLK_50MHZ) begin
        if (RESET) begin
            r_sw_s1 <= 4'b0000;
            r_sw_s2 <= 4'b0000;
            r_bt_s1 <= 1'b0;
            r_bt_s2 <= 1'b0;
        end else begin
            r_sw_s1 <= w_sw_raw;
            r_sw_s2 <= r_sw_s1;
            r_bt_s1 <= BTN_NORTH;
            r_bt_s2 <= r_bt_s1;
        end
    end

    // Switch group: candidate tracking, reload counter and registered strobe
    always_ff @(posedge CLK_50MHZ) begin
        if (RESET) begin
            r_sw_cand    <= 4'b0000;
            r_sw_cnt     <= c_cnt_zero;
            r_sw_stable  <= 4'b0000;
            r_sw_changed <= 1'b0;
        end else begin
            r_sw_changed <= 1'b0;
            if (w_sw_new_cand) begin
                r_sw_cand <= r_sw_s2;
                r_sw_cnt  <= c_cnt_zero;
            end else if (w_sw_accept) begin
                r_sw_stable  <= r_sw_cand;
                r_sw_changed <= 1'b1;
                r_sw_cnt     <= c_cnt_zero;
            end else if (w_sw_pending) begin
                r_sw_cnt <= r_sw_cnt + c_cnt_one;
            end else begin
                // Bounce back to the stable value: nothing pending
                r_sw_cnt <= c_cnt_zero;
            end
        end
    end

    // Button: same structure, plus direction-specific strobes
    always_ff @(posedge CLK_50MHZ) begin
        if (RESET) begin
            r_bt_cand    <= 1'b0;
            r_bt_cnt     <= c_cnt_zero;
            r_bt_level   <= 1'b0;
            r_bt_press   <= 1'b0;
            r_bt_release <= 1'b0;
        end else begin
            r_bt_press   <= 1'b0;
            r_bt_release <= 1'b0;
            if (w_bt_new_cand) begin
                r_bt_cand <= r_bt_s2;
                r_bt_cnt  <= c_cnt_zero;
            end else if (w_bt_accept) begin
                r_bt_level   <= r_bt_cand;
                r_bt_press   <= r_bt_cand;
                r_bt_release <= ~r_bt_cand;
                r_bt_cnt     <= c_cnt_zero;
            end else if (w_bt_pending) begin
                r_bt_cnt <= r_bt_cnt + c_cnt_one;
            end else begin
                r_bt_cnt <= c_cnt_zero;
            end
        end
    end

    assign SW_STABLE   = r_sw_stable;
    assign SW_CHANGED  = r_sw_changed;
    assign BTN_LEVEL   = r_bt_level;
    assign BTN_PRESS   = r_bt_press;
    assign BTN_RELEASE = r_bt_release;

endmodule
`default_nettype wire
